// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Used by the step datapath, the top-level FSM and the testbench model.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_SAT      = 4'd9;
    localparam int         BCD_MAX_2DIG = 99;

    typedef enum logic {IDLE, SHIFT} b2b_state_t;

endpackage

// File: rtl/bin2bcd_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift the
// whole {digits, binary} register left by one.
module bin2bcd_step
    import bcd_pkg::*;
#(
    parameter  int W  = 8,
    localparam int ND = W / 3 + 1,
    localparam int RW = ND * 4 + W
) (
    input  logic [RW-1:0] din,
    output logic [RW-1:0] dout
);

    logic [RW-1:0] adj;

    assign adj[W-1:0] = din[W-1:0];

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_digit
            bcd_digit_t digit;
            assign digit = din[W+4*gi +: 4];
            // Digits stay <= 4'd12 here, so 4-bit addition never carries out.
            assign adj[W+4*gi +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
        end
    endgenerate

    assign dout = {adj[RW-2:0], 1'b0};

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential X/Y binary-to-BCD converter with start/busy/done handshake.
// Both channels share one step counter; results saturate to 99 on overflow.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] bin_x,
    input  logic [W-1:0] bin_y,
    output logic         busy,
    output logic         done,
    output logic [3:0]   bcd_ed_x,
    output logic [3:0]   bcd_des_x,
    output logic [3:0]   bcd_ed_y,
    output logic [3:0]   bcd_des_y,
    output logic         ovf_x,
    output logic         ovf_y
);

    localparam int ND = W / 3 + 1;
    localparam int RW = ND * 4 + W;
    localparam int CW = $clog2(W + 1);

    b2b_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [RW-1:0] sr_x_reg, sr_y_reg;
    logic [RW-1:0] step_x, step_y;
    logic          done_reg, ovf_x_reg, ovf_y_reg;
    bcd_digit_t    ed_x_reg, des_x_reg, ed_y_reg, des_y_reg;
    logic          last_step, sat_x, sat_y;

    bin2bcd_step #(.W(W)) u_step_x (.din(sr_x_reg), .dout(step_x));
    bin2bcd_step #(.W(W)) u_step_y (.din(sr_y_reg), .dout(step_y));

    // Any digit above the tens position means the value does not fit in two digits.
    assign sat_x = |step_x[RW-1:W+8];
    assign sat_y = |step_y[RW-1:W+8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        last_step  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = SHIFT;
            end
            SHIFT: begin
                last_step = (cnt_reg == CW'(W - 1));
                if (last_step) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            sr_x_reg  <= '0;
            sr_y_reg  <= '0;
            done_reg  <= 1'b0;
            ovf_x_reg <= 1'b0;
            ovf_y_reg <= 1'b0;
            ed_x_reg  <= '0;
            des_x_reg <= '0;
            ed_y_reg  <= '0;
            des_y_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (start) begin
                    sr_x_reg <= {{(ND*4){1'b0}}, bin_x};
                    sr_y_reg <= {{(ND*4){1'b0}}, bin_y};
                    cnt_reg  <= '0;
                end
            end else begin
                sr_x_reg <= step_x;
                sr_y_reg <= step_y;
                cnt_reg  <= cnt_reg + 1'b1;
                if (last_step) begin
                    done_reg  <= 1'b1;
                    ovf_x_reg <= sat_x;
                    ovf_y_reg <= sat_y;
                    des_x_reg <= sat_x ? BCD_SAT : step_x[W+4 +: 4];
                    ed_x_reg  <= sat_x ? BCD_SAT : step_x[W   +: 4];
                    des_y_reg <= sat_y ? BCD_SAT : step_y[W+4 +: 4];
                    ed_y_reg  <= sat_y ? BCD_SAT : step_y[W   +: 4];
                end
            end
        end
    end

    assign busy      = (state_reg == SHIFT);
    assign done      = done_reg;
    assign bcd_ed_x  = ed_x_reg;
    assign bcd_des_x = des_x_reg;
    assign bcd_ed_y  = ed_y_reg;
    assign bcd_des_y = des_y_reg;
    assign ovf_x     = ovf_x_reg;
    assign ovf_y     = ovf_y_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: the driver queues expected conversions,
// a negedge monitor checks every done pulse against a decimal reference model.
module tb_bin2bcd_seq;
    import bcd_pkg::*;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] bin_x = '0;
    logic [7:0] bin_y = '0;
    logic       busy, done, ovf_x, ovf_y;
    logic [3:0] bcd_ed_x, bcd_des_x, bcd_ed_y, bcd_des_y;

    bin2bcd_seq #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_x(bin_x), .bin_y(bin_y),
        .busy(busy), .done(done),
        .bcd_ed_x(bcd_ed_x), .bcd_des_x(bcd_des_x),
        .bcd_ed_y(bcd_ed_y), .bcd_des_y(bcd_des_y),
        .ovf_x(ovf_x), .ovf_y(ovf_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   busy_len = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int ref_des(input int v);
        return (v > BCD_MAX_2DIG) ? 9 : v / 10;
    endfunction

    function automatic int ref_ed(input int v);
        return (v > BCD_MAX_2DIG) ? 9 : v % 10;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_len  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_len++;
            if (done) begin
                exp_t e;
                chk("done_one_cycle", int'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc - e.acc, W);
                    chk("busy_cycles", busy_len, W);
                    chk("des_x", int'(bcd_des_x), ref_des(e.x));
                    chk("ed_x", int'(bcd_ed_x), ref_ed(e.x));
                    chk("ovf_x", int'(ovf_x), int'(e.x > BCD_MAX_2DIG));
                    chk("des_y", int'(bcd_des_y), ref_des(e.y));
                    chk("ed_y", int'(bcd_ed_y), ref_ed(e.y));
                    chk("ovf_y", int'(ovf_y), int'(e.y > BCD_MAX_2DIG));
                    $display("conv x=%0d y=%0d -> X %0d%0d ovf=%0d  Y %0d%0d ovf=%0d",
                             e.x, e.y, bcd_des_x, bcd_ed_x, ovf_x, bcd_des_y, bcd_ed_y, ovf_y);
                end
                busy_len = 0;
            end
            prev_done = done;
        end
    end

    // Issue one accepted conversion; returns right after the capture edge.
    task automatic convert(input int x, input int y);
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
        start = 1'b1;
        bin_x = 8'(x);
        bin_y = 8'(y);
        @(posedge clk); #1;
        exp_q.push_back('{x: x, y: y, acc: cyc});
        start = 1'b0;
        bin_x = 8'($urandom);
        bin_y = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 50);
        chk("done_timeout", int'(done), 1);
    endtask

    initial begin
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_digits", int'({bcd_des_x, bcd_ed_x, bcd_des_y, bcd_ed_y}), 0);
        chk("rst_ovf", int'({ovf_x, ovf_y}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        convert(0, 0);     drain();
        convert(42, 7);    drain();
        convert(99, 100);  drain();
        convert(255, 128); drain();

        // Start while busy must be ignored; start in the done cycle is accepted.
        convert(42, 42);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; bin_x = 8'd13; bin_y = 8'd13;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        start = 1'b1; bin_x = 8'd13; bin_y = 8'd13;
        @(posedge clk); #1;
        exp_q.push_back('{x: 13, y: 13, acc: cyc});
        start = 1'b0;
        drain();

        // Reset mid-conversion after a saturated result is on the outputs.
        convert(255, 255); drain();
        start = 1'b1; bin_x = 8'd57; bin_y = 8'd57;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_digits", int'({bcd_des_x, bcd_ed_x, bcd_des_y, bcd_ed_y}), 0);
        chk("midrst_ovf", int'({ovf_x, ovf_y}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        chk("midrst_idle", int'(busy), 0);

        // Random sweep, mostly back-to-back.
        for (int i = 0; i < 40; i++) begin
            convert(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        drain();
        for (int v = 98; v <= 101; v++) convert(v, 199 - v);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
